// File: rtl/addsub_arb_pkg.sv
// Shared constants for the add/sub arbiter: state encodings, requester IDs and the stats counter width.
package addsub_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/addsub_arbiter_rr.sv
// Two-way round-robin grant: on a tie, the requester that did not win last time is granted.
// Purely combinational; the caller owns last_grant and decides when a grant is taken.
module rr_arbiter2
  import addsub_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant0 = valid0 && (!valid1 || (last_grant == REQ1));
    grant1 = valid1 && (!valid0 || (last_grant == REQ0));
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one external add/sub unit between two requesters; latency: accept at T, response pulse at T+2, next accept T+3.
// No response backpressure; readys only in IDLE. Optional grant counters under ADDSUB_ARB_STATS_EN.
module addsub_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic [WIDTH-1:0] req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  input  logic [WIDTH-1:0] req1_cin,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic             au_sub,
  output logic [WIDTH-1:0] au_cin,
  input  logic [WIDTH-1:0] au_sum,
  input  logic             au_cout
`ifdef ADDSUB_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  state_t state;
  state_t state_nxt;
  logic   last_grant;
  logic   owner;
  logic   grant0;
  logic   grant1;
  logic   accept;

  rr_arbiter2 u_rr (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  assign accept = (state == IDLE) && (grant0 || grant1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake and response strobes are masked while reset is held so an aborted op leaves no trace.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = reset_n && grant0;
        req1_ready = reset_n && grant1;
        if (grant0 || grant1) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = DONE;
      end
      DONE: begin
        rsp0_valid = reset_n && (owner == REQ0);
        rsp1_valid = reset_n && (owner == REQ1);
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      au_a       <= '0;
      au_b       <= '0;
      au_sub     <= 1'b0;
      au_cin     <= '0;
      owner      <= REQ0;
      last_grant <= REQ1;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
    end else begin
      if (accept) begin
        owner      <= grant1 ? REQ1 : REQ0;
        last_grant <= grant1 ? REQ1 : REQ0;
        au_a       <= grant1 ? req1_a   : req0_a;
        au_b       <= grant1 ? req1_b   : req0_b;
        au_sub     <= grant1 ? req1_sub : req0_sub;
        au_cin     <= grant1 ? req1_cin : req0_cin;
      end
      if (state == EXEC) begin
        rsp_sum  <= au_sum;
        rsp_cout <= au_cout;
      end
    end
  end

`ifdef ADDSUB_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready) begin
        grant_cnt0 <= grant_cnt0 + 1'b1;
      end
      if (req1_ready) begin
        grant_cnt1 <= grant_cnt1 + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one combinational N-bit adder/subtractor-with-carry-vector (external instance) between two requesters, e.g. the SDRAM address generator and the bus-interface pointer logic.
- Per-requester valid/ready request handshake; round-robin arbitration; operands registered into the shared unit; result registered and returned to the winner with a one-cycle response pulse.
- Sits between the requesters and the arithmetic unit; contains no arithmetic itself.

Parameters:
- WIDTH, 8, operand/result width; also the width of the carry-in vector passed to the unit.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle (valid&ready)
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_sub  in  1  requester 0: 1=subtract, 0=add
- req0_cin  in  WIDTH  requester 0 carry-in vector
- req1_valid, req1_ready, req1_a, req1_b, req1_sub, req1_cin  as above, requester 1
- rsp0_valid  out  1  one-cycle pulse: result for requester 0 on rsp_sum/rsp_cout
- rsp1_valid  out  1  same, requester 1
- rsp_sum  out  WIDTH  registered result, shared by both responses
- rsp_cout  out  1  registered carry-out
- au_a, au_b  out  WIDTH  operands to the shared unit
- au_sub  out  1  mode to the shared unit
- au_cin  out  WIDTH  carry vector to the shared unit
- au_sum  in  WIDTH  unit result (combinational from au_*)
- au_cout  in  1  unit carry-out

Behaviour:
- Clock and reset: single clock domain, clk; reset_n sampled on the rising edge only, active low.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - readys are combinational: at most one ready high, only toward a valid requester.
  - Both valid: grant the requester other than last_grant.
  - One valid: grant it.
  - On a grant: register that requester's a/b/sub/cin into au_*, set owner and last_grant to it, go to EXEC.
  - No valid: stay in IDLE, readys 0.
- EXEC: au_* held stable one full cycle. Capture au_sum into rsp_sum and au_cout into rsp_cout at the end of the cycle, go to DONE. Readys 0.
- DONE: raise rsp<owner>_valid for exactly this cycle, then return to IDLE. Readys 0.
- Latency: handshake at edge T; rsp valid during cycle T+2; next accept possible at T+3.
- Throughput: one operation per 3 cycles.
- Hold behaviour:
  - rsp_sum/rsp_cout keep their last value until the next capture.
  - au_* keep their last value in DONE and IDLE; only a grant updates them.
- No backpressure on responses: the requester must accept the pulse.
- Request-side rules:
  - A requester may drop valid while not granted; nothing is recorded.
  - Operands are sampled only on the handshake edge.
- Reset values: state=IDLE, last_grant=1 (requester 0 wins the first tie), owner=0, au_*=0, rsp_sum=0, rsp_cout=0, rsp0/1_valid=0, readys=0 during reset.
- Reset mid-operation (EXEC or DONE):
  - Abort the operation; no response pulse is issued.
  - The in-flight requester must re-request.
- Fairness: under continuous requests from both sides, grants strictly alternate 0,1,0,1...

Optional Feature:
- Macro ADDSUB_ARB_STATS_EN.
- When defined:
  - Adds outputs grant_cnt0 and grant_cnt1, 16 bits each.
  - Each counter increments on its requester's handshake edge and wraps 0xFFFF->0x0000.
  - Both clear on reset.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package addsub_arb_pkg (localparams):
  - state encodings ST_IDLE=2'd0, ST_EXEC=2'd1, ST_DONE=2'd2.
  - Requester IDs REQ0=1'b0, REQ1=1'b1.
  - Counter width CNT_W=16.
- One natural sub-module: rr_arbiter2. It is combinational grant logic taking valid0/valid1/last_grant and producing grant0/grant1; it is reused elsewhere in the bus interface.
- The FSM and registers stay in addsub_arbiter.

Test Plan:
- The bench drives au_sum/au_cout from a behavioural model: a+b (sub=0) or a-b (sub=1), carry-in 0 in all tests.
- Reset, then req0 only, a=0xAC b=0x01 sub=0 cin=0x00 -> req0_ready at T; au_a=0xAC in EXEC; rsp0_valid at T+2 with rsp_sum=0xAD, rsp_cout=0; rsp1_valid never high.
- Both valid on the same cycle after reset: req0 a=0x10 b=0x05 sub=1, req1 a=0xFF b=0x01 sub=0 -> req0 granted first, rsp0 sum=0x0B; req1 granted next at T+3, rsp1 sum=0x00 cout=1.
- Both held valid for 8 operations -> grant order 0,1,0,1,0,1,0,1; no two responses overlap; no ready asserted outside IDLE.
- Accumulate loop (requester 0 feeds rsp_sum back as a), a=0xAC b=0x01, 10 iterations -> final rsp_sum=0xB6.
- Assert reset_n=0 during EXEC for one cycle -> no rsp pulse; all outputs at reset values; the next grant goes to requester 0.
- With ADDSUB_ARB_STATS_EN: 65537 grants to req0 -> grant_cnt0=0x0001 (wrapped), grant_cnt1=0.
